// File: rtl/tdsp_pso_sequencer.sv
// Power shut-off / wake-up sequencer for the switchable TDSP core domain.
// Orders clock gating, isolation, retention and the switch chain with dwell timers.
module tdsp_pso_sequencer #(
  parameter int unsigned CLK_DLY        = 2,
  parameter int unsigned ISO_DLY        = 2,
  parameter int unsigned SAVE_CYCLES    = 4,
  parameter int unsigned RESTORE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_down,
  input  logic       test_mode,
  input  logic       pwr_ack,
  output logic       pwr_switch_on,
  output logic       isolation_enable,
  output logic       state_retention_enable,
  output logic       state_retention_restore,
  output logic       tdsp_clk_enable,
  output logic [3:0] pwr_state,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [3:0] {
    S_ON       = 4'd0,
    S_CLK_STOP = 4'd1,
    S_ISO_ON   = 4'd2,
    S_SAVE     = 4'd3,
    S_PSW_OFF  = 4'd4,
    S_OFF      = 4'd5,
    S_PSW_ON   = 4'd6,
    S_RESTORE  = 4'd7,
    S_ISO_OFF  = 4'd8
  } state_t;

  localparam logic [7:0] CLK_N  = 8'(CLK_DLY - 1);
  localparam logic [7:0] ISO_N  = 8'(ISO_DLY - 1);
  localparam logic [7:0] SAVE_N = 8'(SAVE_CYCLES - 1);
  localparam logic [7:0] REST_N = 8'(RESTORE_CYCLES - 1);
  localparam logic [7:0] ACK_N  = 8'(ACK_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       err_q;
  logic       err_set;
  logic       cnt_done;

  assign cnt_done = (cnt_q == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ON;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | err_set;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? 8'd0 : cnt_q - 8'd1;
    err_set = 1'b0;
    case (state_q)
      S_ON: begin
        if (power_down && !test_mode) begin
          state_d = S_CLK_STOP;
          cnt_d   = CLK_N;
        end
      end
      S_CLK_STOP: begin
        if (cnt_done) begin
          state_d = S_ISO_ON;
          cnt_d   = ISO_N;
        end
      end
      S_ISO_ON: begin
        if (cnt_done) begin
          state_d = S_SAVE;
          cnt_d   = SAVE_N;
        end
      end
      S_SAVE: begin
        if (cnt_done) begin
          state_d = S_PSW_OFF;
          cnt_d   = ACK_N;
        end
      end
      S_PSW_OFF: begin
        if (!pwr_ack) begin
          state_d = S_OFF;
        end else if (cnt_done) begin
          state_d = S_OFF;
          err_set = 1'b1;
        end
      end
      S_OFF: begin
        if (!power_down || test_mode) begin
          state_d = S_PSW_ON;
          cnt_d   = ACK_N;
        end
      end
      S_PSW_ON: begin
        // a timed-out wake still restores; the sticky flag records it
        if (pwr_ack || cnt_done) begin
          state_d = S_RESTORE;
          cnt_d   = REST_N;
          err_set = !pwr_ack;
        end
      end
      S_RESTORE: begin
        if (cnt_done) begin
          state_d = S_ISO_OFF;
          cnt_d   = ISO_N;
        end
      end
      S_ISO_OFF: begin
        if (cnt_done) begin
          state_d = S_ON;
        end
      end
      default: begin
        state_d = S_ON;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign pwr_state               = state_q;
  assign tdsp_clk_enable         = (state_q == S_ON);
  assign isolation_enable        = (state_q == S_ISO_ON)  || (state_q == S_SAVE)
                                || (state_q == S_PSW_OFF) || (state_q == S_OFF)
                                || (state_q == S_PSW_ON)  || (state_q == S_RESTORE);
  assign state_retention_enable  = (state_q == S_SAVE);
  assign state_retention_restore = (state_q == S_RESTORE);
  assign pwr_switch_on           = !((state_q == S_PSW_OFF) || (state_q == S_OFF));
  assign busy                    = !((state_q == S_ON) || (state_q == S_OFF));
  assign timeout_err             = err_q;

endmodule
